// File: rtl/apb_gpio_irq_if.sv
// APB bus bundle between the APB master/decoder and the GPIO slave.
// The master modport drives the request, the slave modport drives the response.
interface apb_gpio_irq_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STROBE_WIDTH = 4
) ();

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [STROBE_WIDTH-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic                    PREADY;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_gpio_irq.sv
// Parametrised APB GPIO slave: byte-lane register writes, synchronised pad inputs
// and per-pin rise/fall interrupts with write-one-to-clear status.
module apb_gpio_irq #(
  parameter int PIN_NUM      = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STROBE_WIDTH = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int PROT_CHECK   = 0
) (
  input  logic               CLK,
  input  logic               RST,
  apb_gpio_irq_if.slave      apb,
  input  logic [PIN_NUM-1:0] pins_in,
  output logic [PIN_NUM-1:0] pins_out,
  output logic [PIN_NUM-1:0] pins_oe,
  output logic               irq
);

  typedef enum logic [2:0] {
    IDX_DATA_IN  = 3'd0,
    IDX_DIR      = 3'd1,
    IDX_PORT     = 3'd2,
    IDX_IRQ_EN   = 3'd3,
    IDX_IRQ_RISE = 3'd4,
    IDX_IRQ_FALL = 3'd5,
    IDX_IRQ_STAT = 3'd6,
    IDX_INVALID  = 3'd7
  } reg_idx_e;

  localparam int                ARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_MAX = ARM_W'(SYNC_STAGES + 1);

  // Register file
  logic [PIN_NUM-1:0] r_dir;
  logic [PIN_NUM-1:0] r_port;
  logic [PIN_NUM-1:0] r_irq_en;
  logic [PIN_NUM-1:0] r_irq_rise;
  logic [PIN_NUM-1:0] r_irq_fall;
  logic [PIN_NUM-1:0] r_irq_stat;
  logic               r_irq;

  // Input path
  logic [PIN_NUM-1:0] r_sync [SYNC_STAGES];
  logic [PIN_NUM-1:0] r_prev;
  logic [ARM_W-1:0]   r_arm_cnt;

  // Bus decode
  reg_idx_e           w_idx;
  logic               w_access;
  logic               w_err;
  logic               w_wr;
  logic [DATA_WIDTH-1:0] w_lane_mask;
  logic [PIN_NUM-1:0] w_mask;
  logic [PIN_NUM-1:0] w_wdata;
  logic [PIN_NUM-1:0] w_rd_pins;

  // Edge detection
  logic [PIN_NUM-1:0] w_sync;
  logic [PIN_NUM-1:0] w_rise;
  logic [PIN_NUM-1:0] w_fall;
  logic               w_armed;
  logic [PIN_NUM-1:0] w_stat_set;
  logic [PIN_NUM-1:0] w_stat_clr;
  logic               w_unused;

  assign w_idx    = reg_idx_e'(apb.PADDR[4:2]);
  assign w_access = apb.PSEL & apb.PENABLE;

  // An errored access leaves every register untouched, so the error term gates the write strobe.
  assign w_err = (w_idx == IDX_INVALID)
               | (apb.PWRITE & (w_idx == IDX_DATA_IN))
               | ((PROT_CHECK != 0) & apb.PWRITE & ~apb.PPROT[0]);
  assign w_wr  = w_access & apb.PWRITE & ~w_err;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
    assign w_lane_mask[g] = apb.PSTRB[g / 8];
  end

  assign w_mask  = w_lane_mask[PIN_NUM-1:0];
  assign w_wdata = apb.PWDATA[PIN_NUM-1:0];

  // Address bits above the register index, unused protection bits and data/strobe
  // bits beyond the pin count are deliberately ignored.
  assign w_unused = ^{apb.PADDR, apb.PWDATA, apb.PPROT, w_lane_mask};

  function automatic logic [PIN_NUM-1:0] lane_merge(
    input logic [PIN_NUM-1:0] old_val,
    input logic [PIN_NUM-1:0] new_val,
    input logic [PIN_NUM-1:0] mask
  );
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // NOTE: the synchroniser array is reset like any other state so the previous-sample
  // compare never sees X and cannot fake an edge straight out of reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= pins_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;

  // Status capture waits until the synchroniser has flushed its post-reset contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_arm_cnt <= '0;
    end else if (r_arm_cnt != ARM_MAX) begin
      r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  assign w_armed    = (r_arm_cnt == ARM_MAX);
  assign w_stat_set = w_armed ? ((w_rise & r_irq_rise) | (w_fall & r_irq_fall)) : '0;
  assign w_stat_clr = (w_wr && (w_idx == IDX_IRQ_STAT)) ? (w_wdata & w_mask) : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dir      <= '0;
      r_port     <= '0;
      r_irq_en   <= '0;
      r_irq_rise <= '0;
      r_irq_fall <= '0;
      r_irq_stat <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (w_idx == IDX_DIR))      r_dir      <= lane_merge(r_dir, w_wdata, w_mask);
      if (w_wr && (w_idx == IDX_PORT))     r_port     <= lane_merge(r_port, w_wdata, w_mask);
      if (w_wr && (w_idx == IDX_IRQ_EN))   r_irq_en   <= lane_merge(r_irq_en, w_wdata, w_mask);
      if (w_wr && (w_idx == IDX_IRQ_RISE)) r_irq_rise <= lane_merge(r_irq_rise, w_wdata, w_mask);
      if (w_wr && (w_idx == IDX_IRQ_FALL)) r_irq_fall <= lane_merge(r_irq_fall, w_wdata, w_mask);
      // A new edge in the same cycle as its W1C keeps the bit set.
      r_irq_stat <= (r_irq_stat & ~w_stat_clr) | w_stat_set;
      r_irq      <= |(r_irq_stat & r_irq_en);
    end
  end

  // NOTE: the read mux assigns its output before the case so no path infers a latch.
  always_comb begin
    w_rd_pins = '0;
    if (w_access && !apb.PWRITE && !w_err) begin
      case (w_idx)
        IDX_DATA_IN:  w_rd_pins = w_sync;
        IDX_DIR:      w_rd_pins = r_dir;
        IDX_PORT:     w_rd_pins = r_port;
        IDX_IRQ_EN:   w_rd_pins = r_irq_en;
        IDX_IRQ_RISE: w_rd_pins = r_irq_rise;
        IDX_IRQ_FALL: w_rd_pins = r_irq_fall;
        IDX_IRQ_STAT: w_rd_pins = r_irq_stat;
        default:      w_rd_pins = '0;
      endcase
    end
  end

  assign apb.PREADY  = w_access;
  assign apb.PRDATA  = DATA_WIDTH'(w_rd_pins);
  assign apb.PSLVERR = w_access & w_err;

  assign pins_out = r_port;
  assign pins_oe  = r_dir;
  assign irq      = r_irq;

endmodule
